// File: rtl/sfq_arb_pkg.sv
// Shared types and helpers for the SFQ pulse arbiter.
// Holds the FSM state encoding and the index-width helper.
package sfq_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        HOLD = 2'd2
    } arb_state_t;

    // Width needed to index n items; at least one bit so degenerate sizes stay legal.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sfq_pulse_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or after ptr,
// searching upward modulo N.
module rr_pick
    import sfq_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW:0]  cand [N];
    logic [N-1:0] rot;

    // rot[k] is the eligibility of the source k positions past ptr.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [IW:0] sum;
            assign sum      = {1'b0, ptr} + (IW + 1)'(gi);
            assign cand[gi] = (sum >= (IW + 1)'(N)) ? (sum - (IW + 1)'(N)) : sum;
            assign rot[gi]  = elig[cand[gi][IW-1:0]];
        end
    endgenerate

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                idx   = cand[k][IW-1:0];
            end
        end
    end

    generate
        for (gi = 0; gi < N; gi++) begin : g_grant
            assign grant[gi] = valid && (idx == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/sfq_pulse_arbiter.sv
// Round-robin pulse scheduler sharing one RSFQ line among N requesters,
// with a forced recovery gap after every pulse and a saturating pulse counter.
module sfq_pulse_arbiter
    import sfq_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int GAP   = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    input  logic                 cnt_clr,
    output logic                 q,
    output logic [N-1:0]         ack,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     pulse_cnt
);

    localparam int IW = idx_w(N);
    localparam int HW = idx_w(GAP + 1);
    localparam logic [HW-1:0] GAP_V = HW'(GAP);

    arb_state_t    state_reg, state_next;
    logic [HW-1:0] hold_reg, hold_next;
    logic [IW-1:0] ptr_reg, ptr_next;

    logic          fire;
    logic          q_next;
    logic [N-1:0]  ack_next;
    logic [IW-1:0] gnt_next;
    logic          busy_next;

    logic [N-1:0]  elig;
    logic [N-1:0]  pick_grant;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;

    // A source being acked this cycle is not re-eligible until the next cycle.
    assign elig = req & ~mask & ~ack;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .elig  (elig),
        .ptr   (ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        ptr_next   = ptr_reg;
        fire       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    fire = 1'b1;
                end
            end
            FIRE: begin
                if (GAP > 0) begin
                    state_next = HOLD;
                    hold_next  = GAP_V;
                end else if (pick_valid) begin
                    fire = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (hold_reg <= HW'(1)) begin
                    hold_next = '0;
                    if (pick_valid) begin
                        fire = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    hold_next = hold_reg - HW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                hold_next  = '0;
            end
        endcase

        if (fire) begin
            state_next = FIRE;
            ptr_next   = (pick_idx == IW'(N - 1)) ? '0 : (pick_idx + IW'(1));
        end
    end

    // Output values are computed from the next state so every output is a flop.
    always_comb begin
        q_next    = fire;
        ack_next  = fire ? pick_grant : '0;
        gnt_next  = fire ? pick_idx : gnt_id;
        busy_next = (state_next == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            hold_reg  <= '0;
            ptr_reg   <= '0;
            q         <= 1'b0;
            ack       <= '0;
            gnt_id    <= '0;
            busy      <= 1'b0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            ptr_reg   <= ptr_next;
            q         <= q_next;
            ack       <= ack_next;
            gnt_id    <= gnt_next;
            busy      <= busy_next;
        end
    end

    // Counts the pulse at the end of its cycle, so a clear in that same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_cnt <= '0;
        end else if (cnt_clr) begin
            pulse_cnt <= '0;
        end else if (q && (pulse_cnt != {CNT_W{1'b1}})) begin
            pulse_cnt <= pulse_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sfq_pulse_arbiter.sv
// Scoreboard bench for sfq_pulse_arbiter: two instances (GAP=2/CNT_W=8 and
// GAP=0/CNT_W=3) share stimulus and are checked against a timing-rule model.
module tb_sfq_pulse_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] mask = '0;
    logic       cnt_clr = 1'b0;

    logic       q_a, busy_a, q_b, busy_b;
    logic [3:0] ack_a, ack_b;
    logic [1:0] gid_a, gid_b;
    logic [7:0] cnt_a;
    logic [2:0] cnt_b;

    logic [1:0]      q_w, busy_w;
    logic [1:0][3:0] ack_w;
    logic [1:0][1:0] gid_w;
    logic [1:0][7:0] cnt_w;

    assign q_w    = {q_b, q_a};
    assign busy_w = {busy_b, busy_a};
    assign ack_w  = {ack_b, ack_a};
    assign gid_w  = {gid_b, gid_a};
    assign cnt_w  = {{5'b0, cnt_b}, cnt_a};

    always #5 clk = ~clk;

    sfq_pulse_arbiter #(.N(4), .GAP(2), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .cnt_clr(cnt_clr),
        .q(q_a), .ack(ack_a), .gnt_id(gid_a), .busy(busy_a), .pulse_cnt(cnt_a)
    );

    sfq_pulse_arbiter #(.N(4), .GAP(0), .CNT_W(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .cnt_clr(cnt_clr),
        .q(q_b), .ack(ack_b), .gnt_id(gid_b), .busy(busy_b), .pulse_cnt(cnt_b)
    );

    typedef struct {int d; int cyc; int q; int busy; int gid; int cnt;} st_t;
    typedef struct {int d; int cyc; int idx;} gr_t;

    st_t   sq[$];
    gr_t   gq[$];
    st_t   e;
    gr_t   g;
    int    fi;
    int    n_cmp = 0;
    int    n_fail = 0;
    int    cyc = 0;
    string dn[2] = '{"A", "B"};

    // Model: a pulse may fire in cycle c+1 if something is eligible and at
    // least GAP idle cycles have passed since the previous pulse.
    int gap_m[2] = '{2, 0};
    int cmax[2]  = '{255, 7};
    int last_c[2];
    int last_i[2];
    int ptr_m[2];
    int cnt_m[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            last_c[d] = -1000;
            last_i[d] = 0;
            ptr_m[d]  = 0;
            cnt_m[d]  = 0;
        end
        sq.delete();
        gq.delete();
    endtask

    task automatic model_step();
        int         c;
        int         nc;
        int         pick;
        int         fired;
        int         bz;
        logic [3:0] elig;
        c = cyc;
        for (int d = 0; d < 2; d++) begin
            nc = cnt_m[d];
            if (cnt_clr) nc = 0;
            else if (last_c[d] == c) nc = (cnt_m[d] + 1 > cmax[d]) ? cmax[d] : cnt_m[d] + 1;
            elig = req & ~mask;
            if (last_c[d] == c) elig[last_i[d]] = 1'b0;
            fired = 0;
            if (elig != 4'b0 && (c + 1) >= last_c[d] + gap_m[d] + 1) begin
                pick = -1;
                for (int k = 0; k < N; k++) begin
                    if (pick < 0 && elig[(ptr_m[d] + k) % N]) pick = (ptr_m[d] + k) % N;
                end
                fired     = 1;
                last_c[d] = c + 1;
                last_i[d] = pick;
                ptr_m[d]  = (pick + 1) % N;
                gq.push_back('{d, c + 1, pick});
            end
            cnt_m[d] = nc;
            bz = (!fired && (c + 1) > last_c[d] && (c + 1) <= last_c[d] + gap_m[d]) ? 1 : 0;
            sq.push_back('{d, c + 1, fired, bz, last_i[d], nc});
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] m, input logic clr);
        @(negedge clk);
        req = r;
        mask = m;
        cnt_clr = clr;
        model_step();
    endtask

    task automatic release_rst(input logic [3:0] r);
        @(negedge clk);
        rst_n = 1'b1;
        req = r;
        mask = '0;
        cnt_clr = 1'b0;
        model_step();
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_q_", dn[d]}, int'(q_w[d]), 0);
            check({tag, "_ack_", dn[d]}, int'(ack_w[d]), 0);
            check({tag, "_busy_", dn[d]}, int'(busy_w[d]), 0);
            check({tag, "_gnt_id_", dn[d]}, int'(gid_w[d]), 0);
            check({tag, "_pulse_cnt_", dn[d]}, int'(cnt_w[d]), 0);
        end
    endtask

    // Monitor: per-cycle status entries, plus a grant entry popped on each pulse.
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            while (sq.size() > 0 && sq[0].cyc < cyc) begin
                check("stale_status", sq[0].cyc, cyc);
                sq.delete(0);
            end
            while (sq.size() > 0 && sq[0].cyc == cyc) begin
                e = sq[0];
                sq.delete(0);
                check({"q_", dn[e.d]}, int'(q_w[e.d]), e.q);
                check({"busy_", dn[e.d]}, int'(busy_w[e.d]), e.busy);
                check({"gnt_id_", dn[e.d]}, int'(gid_w[e.d]), e.gid);
                check({"pulse_cnt_", dn[e.d]}, int'(cnt_w[e.d]), e.cnt);
            end
            for (int d = 0; d < 2; d++) begin
                if (q_w[d]) begin
                    fi = -1;
                    for (int i = 0; i < gq.size(); i++) begin
                        if (fi < 0 && gq[i].d == d) fi = i;
                    end
                    if (fi < 0) begin
                        check({"unexpected_pulse_", dn[d]}, 1, 0);
                    end else begin
                        g = gq[fi];
                        gq.delete(fi);
                        check({"pulse_cycle_", dn[d]}, cyc, g.cyc);
                        check({"ack_", dn[d]}, int'(ack_w[d]), 1 << g.idx);
                        check({"grant_id_", dn[d]}, int'(gid_w[d]), g.idx);
                    end
                end else begin
                    check({"ack_idle_", dn[d]}, int'(ack_w[d]), 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int found;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        release_rst(4'b0000);

        // single request on source 2
        drive(4'b0100, 4'b0000, 1'b0);
        repeat (6) drive(4'b0000, 4'b0000, 1'b0);

        // full contention
        repeat (16) drive(4'b1111, 4'b0000, 1'b0);
        repeat (4) drive(4'b0000, 4'b0000, 1'b0);

        // all masked, then partial mask
        repeat (50) drive(4'b1111, 4'b1111, 1'b0);
        repeat (12) drive(4'b1111, 4'b0101, 1'b0);
        repeat (4) drive(4'b0000, 4'b0000, 1'b0);

        // back-to-back on the GAP=0 instance, saturation and clear-with-pulse
        repeat (12) drive(4'b0011, 4'b0000, 1'b0);
        drive(4'b0011, 4'b0000, 1'b1);
        repeat (4) drive(4'b0011, 4'b0000, 1'b0);

        // randomized traffic
        repeat (400) begin
            drive(4'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                  ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end

        // reset while instance A is in its recovery gap
        drive(4'b1111, 4'b0000, 1'b0);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk);
            if (busy_w[0]) begin
                found = 1;
            end else begin
                req = 4'b1111;
                mask = '0;
                cnt_clr = 1'b0;
                model_step();
            end
        end
        check("hold_reached", found, 1);
        rst_n = 1'b0;
        #1;
        check_zero("mid_hold_reset");
        model_reset();
        repeat (2) @(negedge clk);
        release_rst(4'b1111);
        repeat (8) drive(4'b1111, 4'b0000, 1'b0);
        repeat (4) drive(4'b0000, 4'b0000, 1'b0);

        repeat (2) @(negedge clk);
        check("grants_outstanding", gq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
